// File: rtl/ibex_trace_buffer_pkg.sv
// Shared types for the on-chip RVFI trace buffer.
//   ibex_trace_state_e : capture FSM encoding (IDLE/ARMED/POST/DONE), visible on state_o
//   ibex_trace_entry_t : base entry layout {pc, insn, trap, intr, trig}
//   trace_entry_w()    : stored entry width, widened when rd_addr/rd_wdata are kept
package ibex_trace_buffer_pkg;

  typedef enum logic [1:0] {
    TRACE_IDLE  = 2'd0,
    TRACE_ARMED = 2'd1,
    TRACE_POST  = 2'd2,
    TRACE_DONE  = 2'd3
  } ibex_trace_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic        trap;
    logic        intr;
    logic        trig;
  } ibex_trace_entry_t;

  localparam int unsigned TraceEntryW = $bits(ibex_trace_entry_t);  // 67
  localparam int unsigned TraceRdW    = 32 + 5;                       // rd_wdata + rd_addr

  function automatic int unsigned trace_entry_w(input bit rd_data);
    return rd_data ? TraceEntryW + TraceRdW : TraceEntryW;
  endfunction

endpackage

// File: rtl/ibex_trace_ram.sv
// Trace storage: Depth x Width flop array, one synchronous write port and one
// asynchronous read port. Data flops have no reset; validity is tracked by the
// owner's pointers/counters.
//   clk_i    : clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : combinational read data
module ibex_trace_ram #(
  parameter  int unsigned Depth = 16,
  parameter  int unsigned Width = 67,
  localparam int unsigned AW    = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ibex_trace_buffer.sv
// Instruction trace capture on the RVFI retirement port. Retired instructions
// are stored in a circular buffer; a PC-match or trap trigger ends the
// pre-trigger window, PostTrigDepth further entries are captured, then the
// buffer freezes and is drained oldest-first over a valid/ready port.
//   clk_i, rst_ni            : clock, async active-low reset
//   arm_i                    : clear buffer, start pre-trigger capture
//   trig_pc_en_i, trig_pc_i  : PC-match trigger
//   rvfi_*                   : retirement tap from ibex_top
//   state_o, done_o          : FSM state, capture complete
//   count_o, overflow_o      : entries held, pre-trigger data lost
//   rd_req_i, rd_valid_o,
//   rd_data_o, rd_last_o     : readout handshake
module ibex_trace_buffer
  import ibex_trace_buffer_pkg::*;
#(
  parameter  int unsigned Depth         = 16,
  parameter  int unsigned PostTrigDepth = 8,
  parameter  logic        TraceRdData   = 1'b0,
  parameter  logic        TrigOnTrap    = 1'b1,
  localparam int unsigned CW            = $clog2(Depth),
  localparam int unsigned EntryW        = trace_entry_w(TraceRdData)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              arm_i,
  input  logic              trig_pc_en_i,
  input  logic [31:0]       trig_pc_i,
  input  logic              rvfi_valid,
  input  logic [31:0]       rvfi_pc_rdata,
  input  logic [31:0]       rvfi_insn,
  input  logic              rvfi_trap,
  input  logic              rvfi_intr,
  input  logic [4:0]        rvfi_rd_addr,
  input  logic [31:0]       rvfi_rd_wdata,
  output logic [1:0]        state_o,
  output logic              done_o,
  output logic [CW:0]       count_o,
  output logic              overflow_o,
  input  logic              rd_req_i,
  output logic              rd_valid_o,
  output logic [EntryW-1:0] rd_data_o,
  output logic              rd_last_o
);

  // post counter needs at least one bit even when the post window is empty
  localparam int unsigned PW       = (PostTrigDepth > 0) ? $clog2(PostTrigDepth + 1) : 1;
  localparam logic [CW:0] DepthCnt = (CW+1)'(Depth);
  localparam logic [PW-1:0] PostInit = PW'(PostTrigDepth);

  ibex_trace_state_e state_q, state_d;
  logic [CW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW:0]       cnt_q, cnt_d;
  logic [PW-1:0]     post_q, post_d;
  logic              ovf_q, ovf_d;

  logic              hit, wr_en, trig_bit;
  ibex_trace_entry_t entry;
  logic [EntryW-1:0] wdata, rdata;

  assign hit = rvfi_valid &
               ((trig_pc_en_i & (rvfi_pc_rdata == trig_pc_i)) | (TrigOnTrap & rvfi_trap));

  // arm wins over capture: a retirement in the arming cycle is dropped
  assign wr_en    = rvfi_valid & ~arm_i &
                    ((state_q == TRACE_ARMED) | (state_q == TRACE_POST));
  assign trig_bit = hit & (state_q == TRACE_ARMED);

  assign entry = '{pc: rvfi_pc_rdata, insn: rvfi_insn, trap: rvfi_trap,
                   intr: rvfi_intr, trig: trig_bit};

  if (TraceRdData) begin : g_rd_data
    assign wdata = {rvfi_rd_wdata, rvfi_rd_addr, entry};
  end else begin : g_no_rd_data
    logic unused_rd;
    assign unused_rd = ^{rvfi_rd_addr, rvfi_rd_wdata};
    assign wdata     = entry;
  end

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    post_d  = post_q;
    ovf_d   = ovf_q;

    if (arm_i) begin
      state_d = TRACE_ARMED;
      wptr_d  = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      if (wr_en) begin
        wptr_d = wptr_q + 1'b1;
        // full buffer: the write lands on the oldest entry, count stays put
        if (cnt_q == DepthCnt) ovf_d = 1'b1;
        else                   cnt_d = cnt_q + 1'b1;
      end

      unique case (state_q)
        TRACE_ARMED: begin
          if (hit) begin
            if (PostTrigDepth == 0) begin
              state_d = TRACE_DONE;
            end else begin
              state_d = TRACE_POST;
              post_d  = PostInit;
            end
          end
        end
        TRACE_POST: begin
          if (rvfi_valid) begin
            post_d = post_q - 1'b1;
            if (post_q == PW'(1)) state_d = TRACE_DONE;
          end
        end
        TRACE_DONE: begin
          if (rd_req_i && (cnt_q != '0)) begin
            rptr_d = rptr_q + 1'b1;
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == (CW+1)'(1)) state_d = TRACE_IDLE;
          end
        end
        default: ;
      endcase

      // oldest entry sits at wptr once the buffer has wrapped, else at 0
      if ((state_d == TRACE_DONE) && (state_q != TRACE_DONE)) begin
        rptr_d = (cnt_d == DepthCnt) ? wptr_d : '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= TRACE_IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      post_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      post_q  <= post_d;
      ovf_q   <= ovf_d;
    end
  end

  ibex_trace_ram #(
    .Depth (Depth),
    .Width (EntryW)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (wr_en),
    .waddr_i (wptr_q),
    .wdata_i (wdata),
    .raddr_i (rptr_q),
    .rdata_o (rdata)
  );

  assign state_o    = state_q;
  assign done_o     = (state_q == TRACE_DONE);
  assign count_o    = cnt_q;
  assign overflow_o = ovf_q;
  assign rd_valid_o = done_o & (cnt_q != '0);
  assign rd_last_o  = done_o & (cnt_q == (CW+1)'(1));
  // gate the array output so unwritten (X) entries never reach the port
  assign rd_data_o  = rd_valid_o ? rdata : '0;

endmodule

// File: tb/tb_ibex_trace_buffer.sv
module tb_ibex_trace_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arm, pc_en, valid, trap, intr, rd_req;
  logic [31:0] trig_pc, pc, insn, rd_wdata;
  logic [4:0]  rd_addr;

  logic [1:0]  state0, state1;
  logic        done0, done1, ovf0, ovf1, rdv0, rdv1, last0, last1;
  logic [4:0]  count0, count1;
  logic [66:0] rdd0, rdd1;

  int pass_cnt = 0;
  int total    = 0;
  logic [66:0] q0[$];
  logic [66:0] q1[$];

  always #5 clk = ~clk;

  ibex_trace_buffer #(.Depth(16), .PostTrigDepth(8), .TraceRdData(1'b0), .TrigOnTrap(1'b1)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .arm_i(arm), .trig_pc_en_i(pc_en), .trig_pc_i(trig_pc),
    .rvfi_valid(valid), .rvfi_pc_rdata(pc), .rvfi_insn(insn), .rvfi_trap(trap),
    .rvfi_intr(intr), .rvfi_rd_addr(rd_addr), .rvfi_rd_wdata(rd_wdata),
    .state_o(state0), .done_o(done0), .count_o(count0), .overflow_o(ovf0),
    .rd_req_i(rd_req), .rd_valid_o(rdv0), .rd_data_o(rdd0), .rd_last_o(last0));

  ibex_trace_buffer #(.Depth(16), .PostTrigDepth(0), .TraceRdData(1'b0), .TrigOnTrap(1'b1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .arm_i(arm), .trig_pc_en_i(pc_en), .trig_pc_i(trig_pc),
    .rvfi_valid(valid), .rvfi_pc_rdata(pc), .rvfi_insn(insn), .rvfi_trap(trap),
    .rvfi_intr(intr), .rvfi_rd_addr(rd_addr), .rvfi_rd_wdata(rd_wdata),
    .state_o(state1), .done_o(done1), .count_o(count1), .overflow_o(ovf1),
    .rd_req_i(rd_req), .rd_valid_o(rdv1), .rd_data_o(rdd1), .rd_last_o(last1));

  function automatic logic [31:0] pc_of(input int k);
    return 32'h0000_1000 + 32'(k) * 32'd4;
  endfunction

  function automatic logic [31:0] insn_of(input int k);
    return 32'h0000_0013 | (32'(k) << 20);
  endfunction

  function automatic logic [66:0] exp_entry(input int k, input logic tp, input logic ir, input logic tg);
    return {pc_of(k), insn_of(k), tp, ir, tg};
  endfunction

  // called at a negedge; one retirement captured on the following posedge
  task automatic retire(input int k, input logic tp, input logic ir, input logic tg);
    valid = 1'b1; pc = pc_of(k); insn = insn_of(k); trap = tp; intr = ir;
    rd_addr = 5'(k); rd_wdata = ~pc_of(k);
    q0.push_back(exp_entry(k, tp, ir, tg));
    if (q0.size() > 16) void'(q0.pop_front());
    @(negedge clk);
    valid = 1'b0; trap = 1'b0; intr = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    q0.delete();
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({state0, done0, count0, ovf0, rdv0, rdd0, last0} !== '0) $display("FAIL reset_dut0 got state=%0d cnt=%0d ovf=%b v=%b d=%h l=%b want all 0", state0, count0, ovf0, rdv0, rdd0, last0);
    else pass_cnt++;
    total++;
    if ({state1, done1, count1, ovf1, rdv1, rdd1, last1} !== '0) $display("FAIL reset_dut1 got state=%0d cnt=%0d want all 0", state1, count1);
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_pc_trigger();
    pc_en = 1'b1; trig_pc = pc_of(5);
    do_arm();
    total++;
    if (state0 !== 2'd1 || count0 !== 5'd0) $display("FAIL arm_state got state=%0d cnt=%0d want 1/0", state0, count0);
    else pass_cnt++;
    for (int k = 0; k < 6; k++) retire(k, 1'b0, 1'b0, k == 5);
    total++;
    if (state0 !== 2'd2 || count0 !== 5'd6) $display("FAIL pc_post_state got state=%0d cnt=%0d want 2/6", state0, count0);
    else pass_cnt++;
    for (int k = 6; k < 14; k++) retire(k, 1'b0, 1'b0, 1'b0);
    total++;
    if (state0 !== 2'd3 || done0 !== 1'b1 || count0 !== 5'd14 || ovf0 !== 1'b0)
      $display("FAIL pc_done got state=%0d done=%b cnt=%0d ovf=%b want 3/1/14/0", state0, done0, count0, ovf0);
    else pass_cnt++;
    rd_req = 1'b1;
    for (int i = 0; i < 14; i++) begin
      total++;
      if (rdv0 !== 1'b1 || rdd0 !== q0[i] || last0 !== (i == 13))
        $display("FAIL pc_read%0d got v=%b d=%h l=%b want 1 %h %b", i, rdv0, rdd0, last0, q0[i], i == 13);
      else pass_cnt++;
      @(negedge clk);
    end
    rd_req = 1'b0;
    total++;
    if (state0 !== 2'd0 || rdv0 !== 1'b0 || count0 !== 5'd0) $display("FAIL pc_idle got state=%0d v=%b cnt=%0d want 0/0/0", state0, rdv0, count0);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    pc_en = 1'b1; trig_pc = pc_of(40);
    do_arm();
    for (int k = 0; k < 49; k++) retire(k, 1'b0, 1'b0, k == 40);
    total++;
    if (state0 !== 2'd3 || count0 !== 5'd16 || ovf0 !== 1'b1)
      $display("FAIL ovf_done got state=%0d cnt=%0d ovf=%b want 3/16/1", state0, count0, ovf0);
    else pass_cnt++;
    total++;
    if (rdd0 !== exp_entry(33, 1'b0, 1'b0, 1'b0)) $display("FAIL ovf_first got %h want %h", rdd0, exp_entry(33, 1'b0, 1'b0, 1'b0));
    else pass_cnt++;
    rd_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (rdv0 !== 1'b1 || rdd0 !== q0[i] || rdd0[0] !== (i == 7) || last0 !== (i == 15))
        $display("FAIL ovf_read%0d got v=%b d=%h l=%b want 1 %h %b", i, rdv0, rdd0, last0, q0[i], i == 15);
      else pass_cnt++;
      @(negedge clk);
    end
    rd_req = 1'b0;
    total++;
    if (state0 !== 2'd0) $display("FAIL ovf_idle got state=%0d want 0", state0);
    else pass_cnt++;
  endtask

  task automatic test_trap_trigger();
    pc_en = 1'b0; trig_pc = pc_of(0);
    do_arm();
    for (int k = 0; k < 12; k++) retire(k, (k == 3) || (k == 4), k == 5, k == 3);
    total++;
    if (state0 !== 2'd3 || count0 !== 5'd12) $display("FAIL trap_done got state=%0d cnt=%0d want 3/12", state0, count0);
    else pass_cnt++;
    rd_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      total++;
      if (rdv0 !== 1'b1 || rdd0 !== q0[i] || last0 !== (i == 11))
        $display("FAIL trap_read%0d got v=%b d=%h l=%b want 1 %h %b", i, rdv0, rdd0, last0, q0[i], i == 11);
      else pass_cnt++;
      @(negedge clk);
    end
    rd_req = 1'b0;
  endtask

  task automatic test_post0();
    pc_en = 1'b1; trig_pc = pc_of(2);
    do_arm();
    q1.delete();
    for (int k = 0; k < 3; k++) begin
      q1.push_back(exp_entry(k, 1'b0, 1'b0, k == 2));
      retire(k, 1'b0, 1'b0, k == 2);
    end
    total++;
    if (state1 !== 2'd3 || count1 !== 5'd3 || state0 !== 2'd2)
      $display("FAIL post0_done got state1=%0d cnt1=%0d state0=%0d want 3/3/2", state1, count1, state0);
    else pass_cnt++;
    rd_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (rdv1 !== 1'b1 || rdd1 !== q1[i] || last1 !== (i == 2))
        $display("FAIL post0_read%0d got v=%b d=%h l=%b want 1 %h %b", i, rdv1, rdd1, last1, q1[i], i == 2);
      else pass_cnt++;
      @(negedge clk);
    end
    rd_req = 1'b0;
    total++;
    if (state1 !== 2'd0 || state0 !== 2'd2) $display("FAIL post0_idle got state1=%0d state0=%0d want 0/2", state1, state0);
    else pass_cnt++;
  endtask

  task automatic test_arm_in_done();
    logic [66:0] held;
    pc_en = 1'b1; trig_pc = pc_of(1);
    do_arm();
    for (int k = 0; k < 10; k++) retire(k, 1'b0, 1'b0, k == 1);
    total++;
    if (state0 !== 2'd3 || count0 !== 5'd10) $display("FAIL hold_done got state=%0d cnt=%0d want 3/10", state0, count0);
    else pass_cnt++;
    held = q0[0];
    for (int c = 0; c < 20; c++) begin
      total++;
      if (rdd0 !== held || state0 !== 2'd3 || count0 !== 5'd10)
        $display("FAIL hold_c%0d got d=%h state=%0d cnt=%0d want %h/3/10", c, rdd0, state0, count0, held);
      else pass_cnt++;
      @(negedge clk);
    end
    arm = 1'b1; valid = 1'b1; pc = pc_of(100); insn = insn_of(100);
    @(negedge clk);
    arm = 1'b0; valid = 1'b0;
    total++;
    if (state0 !== 2'd1 || count0 !== 5'd0 || ovf0 !== 1'b0 || rdv0 !== 1'b0)
      $display("FAIL arm_done got state=%0d cnt=%0d ovf=%b v=%b want 1/0/0/0", state0, count0, ovf0, rdv0);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (count0 !== 5'd0) $display("FAIL arm_drop got cnt=%0d want 0", count0);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    pc_en = 1'b1; trig_pc = pc_of(2);
    do_arm();
    for (int k = 0; k < 5; k++) retire(k, 1'b0, 1'b0, k == 2);
    total++;
    if (state0 !== 2'd2 || count0 !== 5'd5) $display("FAIL rstmid_pre got state=%0d cnt=%0d want 2/5", state0, count0);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total++;
    if ({state0, done0, count0, ovf0, rdv0, rdd0, last0} !== '0 || state1 !== 2'd0)
      $display("FAIL rstmid_async got state0=%0d cnt0=%0d v=%b state1=%0d want 0", state0, count0, rdv0, state1);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) retire(k, 1'b0, 1'b0, 1'b0);
    total++;
    if (state0 !== 2'd0 || count0 !== 5'd0 || rdv0 !== 1'b0)
      $display("FAIL rstmid_nocap got state=%0d cnt=%0d v=%b want 0/0/0", state0, count0, rdv0);
    else pass_cnt++;
  endtask

  initial begin
    arm = 1'b0; pc_en = 1'b0; valid = 1'b0; trap = 1'b0; intr = 1'b0; rd_req = 1'b0;
    trig_pc = '0; pc = '0; insn = '0; rd_addr = '0; rd_wdata = '0;
    test_reset();
    test_pc_trigger();
    test_overflow();
    test_trap_trigger();
    test_post0();
    test_arm_in_done();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
